// File: rtl/spi_pkg.sv
// Shared types and command encodings for the parametrised SPI slave.
package spi_pkg;

  localparam int CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

  // Gray sequence along the normal read path: one bit flips per step.
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    CHK_CMD = 3'b001,
    RECV    = 3'b011,
    WAIT_TX = 3'b010,
    SEND    = 3'b110,
    HOLD    = 3'b111
  } spi_state_e;

endpackage

// File: rtl/spi_slave_param_piso.sv
// Parallel-load serial-out shifter driving MISO; output is forced low unless a word is active.
module spi_piso #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic              sout
);

  logic [DATA_W-1:0] sr;
  logic              active;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sr     <= '0;
      active <= 1'b0;
    end else if (load) begin
      sr     <= data;
      active <= 1'b1;
    end else if (shift) begin
      sr <= MSB_FIRST ? {sr[DATA_W-2:0], 1'b0} : {1'b0, sr[DATA_W-1:1]};
    end
  end

  assign sout = active & (MSB_FIRST ? sr[DATA_W-1] : sr[0]);

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front end: receives {cmd, payload} frames and serialises RAM read data on MISO.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              busy
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int WAIT_W  = $clog2(TX_TIMEOUT + 1);

  spi_state_e         state, nstate;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [FRAME_W-1:0] rx_shift, rx_next;
  logic               last_bit, frame_rd, wait_done;
  logic               abort, capture, rx_load, tx_load, tx_shift, tx_clear;
  logic               ferr_set, tout_set;

  assign rx_next   = MSB_FIRST ? {rx_shift[FRAME_W-2:0], MOSI} : {MOSI, rx_shift[FRAME_W-1:1]};
  assign last_bit  = (bit_cnt == CNT_W'(1));
  assign frame_rd  = (rx_next[FRAME_W-1 -: CMD_W] == CMD_RD_DATA);
  assign wait_done = (wait_cnt == WAIT_W'(TX_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // SS_n release outranks every completion condition.
  always_comb begin
    nstate = state;
    if (state != IDLE && SS_n) begin
      nstate = IDLE;
    end else begin
      case (state)
        IDLE:    if (!SS_n) nstate = CHK_CMD;
        CHK_CMD: nstate = RECV;
        RECV:    if (last_bit) nstate = frame_rd ? WAIT_TX : HOLD;
        WAIT_TX: begin
          if (tx_valid)       nstate = SEND;
          else if (wait_done) nstate = HOLD;
        end
        SEND:    if (bit_cnt == '0) nstate = HOLD;
        HOLD:    nstate = HOLD;
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    abort    = (state != IDLE) && SS_n;
    capture  = (state == RECV) && !SS_n;
    rx_load  = capture && last_bit;
    tx_load  = (state == WAIT_TX) && !SS_n && tx_valid;
    tx_shift = (state == SEND) && !SS_n && (bit_cnt != '0);
    tx_clear = abort || ((state == SEND) && !SS_n && (bit_cnt == '0));
    ferr_set = SS_n && (state inside {CHK_CMD, RECV, WAIT_TX, SEND});
    tout_set = (state == WAIT_TX) && !SS_n && !tx_valid && wait_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rx_valid    <= rx_load;
      frame_err   <= ferr_set;
      timeout_err <= tout_set;
      if (state == CHK_CMD)  bit_cnt <= CNT_W'(FRAME_W);
      else if (capture)      bit_cnt <= bit_cnt - 1'b1;
      else if (tx_load)      bit_cnt <= CNT_W'(DATA_W - 1);
      else if (tx_shift)     bit_cnt <= bit_cnt - 1'b1;
      if (capture) rx_shift <= rx_next;
      if (rx_load) rx_data  <= rx_next;
      if (state != WAIT_TX)          wait_cnt <= '0;
      else if (!SS_n && !tx_valid)   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);

  spi_piso #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .shift (tx_shift),
    .clear (tx_clear),
    .data  (tx_data),
    .sout  (MISO)
  );

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front end for the SPI wrapper: deserialises a command-plus-data frame from MOSI, presents it on `rx_data` with a one-cycle `rx_valid` strobe, and, for read-data commands, waits for `tx_data`/`tx_valid` from the backing RAM before serialising it on MISO. It generalises the existing fixed 10-bit slave:
- data width and bit order are parameters;
- read decode is per frame, with no sticky address/data flag;
- `rx_data` is stable between frames;
- aborted frames and missing read data are flagged.

## Interface
- `DATA_W`, 8: payload bits per frame (≥2); frame width `FRAME_W = 2 + DATA_W`.
- `MSB_FIRST`, 1: 1 = MSB first on MOSI and MISO; 0 = LSB first.
- `TX_TIMEOUT`, 16: max WAIT_TX cycles without `tx_valid` (≥1).

Ports:
- `clk`  in  1  serial clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in.
- `MISO`  out  1  serial data out; 0 when not sending.
- `rx_data`  out  FRAME_W  last complete frame, `{cmd[1:0], payload}`.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `tx_data`  in  DATA_W  read data from RAM.
- `tx_valid`  in  1  `tx_data` valid; sampled only in WAIT_TX.
- `frame_err`  out  1  one-cycle strobe: SS_n rose mid-frame or mid-send.
- `timeout_err`  out  1  one-cycle strobe: WAIT_TX expired.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Reset**: state IDLE; `MISO`, `rx_data`, `rx_valid`, `frame_err`, `timeout_err` are 0. Counters and shift registers are 0.
- **IDLE**: on `SS_n` = 0, go to CHK_CMD. No bit is captured.
- **CHK_CMD**: turnaround cycle with no capture. Load the bit counter with `FRAME_W`, then go to RECV.
- **RECV**: each edge shifts MOSI into the rx shift register (in the order set by `MSB_FIRST`) and decrements the counter.
  - On the last bit, load `rx_data` with the full frame (including that bit) and pulse `rx_valid`.
  - If `cmd` = `CMD_RD_DATA` (2'b11), go to WAIT_TX; otherwise go to HOLD.
- **WAIT_TX**: on `tx_valid` = 1, latch `tx_data`, drive the first bit onto MISO at the same edge, set the counter to `DATA_W-1`, and go to SEND.
  - Otherwise increment the wait counter. On reaching `TX_TIMEOUT`, pulse `timeout_err` and go to HOLD with MISO = 0.
- **SEND**: each edge drives the next bit onto MISO and decrements the counter.
  - At counter 0, go to HOLD and set MISO to 0 on that edge.
- **HOLD**: frame complete; ignore MOSI and `tx_valid`. Leave only on `SS_n` = 1.
- **SS_n = 1 in any non-IDLE state**: go to IDLE next edge and clear MISO.
  - If the state was CHK_CMD, RECV, WAIT_TX or SEND, also pulse `frame_err`.
  - `rx_data` keeps its previous frame; no `rx_valid` for a partial frame.
- **SS_n vs. completion**: SS_n rising on the same edge as the last RECV bit takes priority, giving `frame_err` and no `rx_valid`. The same applies to `tx_valid` arriving with SS_n high.
- **Back-to-back frames**: SS_n low again in the cycle after IDLE is re-entered starts a new frame.
- **Reset mid-frame**: reset dominates all transitions and returns the block to the reset state.

## Timing
- E0 is the edge where IDLE samples `SS_n` = 0.
  - CHK_CMD occupies E1.
  - Bits are captured at E2..E(FRAME_W+1).
  - `rx_valid` is high for the cycle after E(FRAME_W+1). For the defaults: E2..E11 capture; `rx_valid` follows E11.
- Read latency:
  - `tx_valid` seen at edge Et puts bit 0 on MISO after Et.
  - The final bit appears after Et+DATA_W-1.
  - MISO returns to 0 after Et+DATA_W.
- `frame_err` and `timeout_err` are single-cycle, mutually exclusive per frame, and registered.
- `busy` is registered from state; it goes high the cycle after E0.

## Structure
- Package `spi_pkg` holds:
  - state enum `spi_state_e` (IDLE, CHK_CMD, RECV, WAIT_TX, SEND, HOLD, gray-encoded);
  - `CMD_W = 2`;
  - command constants `CMD_WR_ADDR = 2'b00`, `CMD_WR_DATA = 2'b01`, `CMD_RD_ADDR = 2'b10`, `CMD_RD_DATA = 2'b11`.
- One sub-module, `spi_piso` (parallel-load, serial-out, parameterised by `DATA_W` and `MSB_FIRST`), drives MISO. The FSM, rx shift, counters and flags stay in the top module.

## Test plan
- **Write frame**: `DATA_W` = 8, MSB first, frame 10'b00_1010_0101 → `rx_data` = 0x0A5 with one `rx_valid` pulse after E11; MISO stays 0; then HOLD until SS_n rises.
- **Read data**: frame 10'b11_xxxx_xxxx; `tx_valid` with `tx_data` = 0xC3 arrives 3 cycles after `rx_valid` → MISO carries 1,1,0,0,0,0,1,1 on consecutive cycles, then 0.
- **LSB first**: `MSB_FIRST` = 0, `DATA_W` = 12, payload 0x5A3 sent LSB first → `rx_data` payload = 0x5A3; a read returns `tx_data` LSB first.
- **Abort**: SS_n rises after 6 RECV bits → `frame_err` pulses once, `rx_valid` stays 0, `rx_data` keeps the prior frame, and the next frame decodes correctly.
- **Timeout**: read-data frame with `tx_valid` held low and `TX_TIMEOUT` = 4 → `timeout_err` pulses after the 4th WAIT_TX cycle, MISO stays 0, and `busy` stays high until SS_n rises.
- **Reset mid-SEND**: `rst_n` = 0 during bit 3 → all outputs 0 next cycle and state IDLE.
